// File: rtl/mul_pp_final_adder.sv
// Final carry-propagate adder for the 16x16 Booth multiplier: two-stage (low half, then high half)
// with valid/ready on both sides. Define MUL_ACC_EN to add a 32-bit accumulator and the acc_clr input.
module mul_pp_final_adder #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      ppout1,
    input  logic [29:0]      ppout2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      product,
    output logic [TAG_W-1:0] out_tag
`ifdef MUL_ACC_EN
    ,
    input  logic             acc_clr
`endif
);

    logic             s1_valid_q, s2_valid_q;
    logic [16:0]      s1_lo_q;
    logic [15:0]      s1_a_q, s1_b_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
    logic [31:0]      s2_prod_q;

    logic        s2_adv, s1_adv, in_fire, s1_move;
    logic [16:0] lo_d;
    logic [15:0] hi_d;
    logic [31:0] result, s2_prod_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;
    assign s1_move  = s1_valid_q && s2_adv;

    assign out_valid = s2_valid_q;
    assign product   = s2_prod_q;
    assign out_tag   = s2_tag_q;

    // ppout2 carries weight 2^(k+2), so its low 14 bits align with ppout1[15:2].
    assign lo_d   = {1'b0, ppout1[15:0]} + {1'b0, ppout2[13:0], 2'b00};
    assign hi_d   = s1_a_q + s1_b_q + {15'd0, s1_lo_q[16]};
    assign result = {hi_d, s1_lo_q[15:0]};

`ifdef MUL_ACC_EN
    logic        s1_clr_q;
    logic [31:0] acc_q;

    // Accumulate only on the S2 load so a stalled result is never added twice.
    assign s2_prod_d = (s1_clr_q ? 32'd0 : acc_q) + result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_clr_q <= 1'b0;
            acc_q    <= 32'd0;
        end else begin
            if (in_fire) s1_clr_q <= acc_clr;
            if (s1_move) acc_q    <= s2_prod_d;
        end
    end
`else
    assign s2_prod_d = result;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_prod_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (in_fire) begin
                s1_lo_q  <= lo_d;
                s1_a_q   <= ppout1[31:16];
                s1_b_q   <= ppout2[29:14];
                s1_tag_q <= in_tag;
            end
            if (s1_move) begin
                s2_prod_q <= s2_prod_d;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_pp_final_adder.sv
// Bench for mul_pp_final_adder: directed corner cases, backpressure, mid-flight reset and a
// randomized handshake run scored against an arithmetic reference model.
module tb_mul_pp_final_adder;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      ppout1 = '0;
    logic [29:0]      ppout2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      product;
    logic [TAG_W-1:0] out_tag;
    logic             acc_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    mul_pp_final_adder #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ppout1(ppout1), .ppout2(ppout2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .out_tag(out_tag)
`ifdef MUL_ACC_EN
        , .acc_clr(acc_clr)
`endif
    );

    always #5 clk = ~clk;

    // Reference: the product is just the weighted sum of the two vectors, modulo 2^32.
    function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [29:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b) * 4;
        return s[31:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; out_ready = 0; acc_clr = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || product !== 32'd0 || out_tag !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b product=%h out_tag=%h in_ready=%b, want 0/0/0/1",
                     out_valid, product, out_tag, in_ready);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_directed();
        logic [31:0] p1 [4];
        logic [29:0] p2 [4];
        logic [31:0] ex [4];
        p1[0] = 32'h0000_0005; p2[0] = 30'h1;        ex[0] = 32'h0000_0009;
        p1[1] = 32'h0000_FFFF; p2[1] = 30'h1;        ex[1] = 32'h0001_0003;
        p1[2] = 32'hFFFF_FFFF; p2[2] = 30'h1;        ex[2] = 32'h0000_0003;
        // -32768 * 3 in redundant form: 0x4000 + (0x3FFF9000 << 2)
        p1[3] = 32'h0000_4000; p2[3] = 30'h3FFF_9000; ex[3] = 32'hFFFE_8000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1; out_ready = 1;
            ppout1 = p1[i]; ppout2 = p2[i]; in_tag = TAG_W'(i + 3);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 0;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || product !== ex[i] || out_tag !== TAG_W'(i + 3)) begin
                n_err++;
                $display("FAIL dir%0d_result: valid=%b product=%h tag=%0d, want 1/%h/%0d",
                         i, out_valid, product, out_tag, ex[i], i + 3);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_drain: out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 0; in_valid = 1;
        ppout1 = 32'd100; ppout2 = 30'd1; in_tag = 1;
        @(negedge clk);
        ppout1 = 32'd200; ppout2 = 30'd2; in_tag = 2;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_accept2: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        ppout1 = 32'd300; ppout2 = 30'd3; in_tag = 3;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1 || product !== 32'd104) begin
                n_err++;
                $display("FAIL bp_hold%0d: in_ready=%b valid=%b tag=%0d product=%0d, want 0/1/1/104",
                         c, in_ready, out_valid, out_tag, product);
            end
            @(negedge clk);
        end
        out_ready = 1;
        for (int t = 1; t <= 3; t++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_tag !== TAG_W'(t) || product !== 32'(t * 104)) begin
                n_err++;
                $display("FAIL bp_order%0d: valid=%b tag=%0d product=%0d, want 1/%0d/%0d",
                         t, out_valid, out_tag, product, t, t * 104);
            end
            @(negedge clk);
            in_valid = 0;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 0; in_valid = 1;
        ppout1 = 32'h1234; ppout2 = 30'h11; in_tag = 5;
        @(negedge clk);
        ppout1 = 32'h5678; ppout2 = 30'h22; in_tag = 6;
        @(negedge clk);
        in_valid = 0;
        #2 rst = 1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || product !== 32'd0 || out_tag !== '0) begin
            n_err++;
            $display("FAIL midrst_flush: valid=%b product=%h tag=%0d, want 0/0/0", out_valid, product, out_tag);
        end
        @(negedge clk);
        rst = 0;
        out_ready = 1; in_valid = 1;
        ppout1 = 32'h0000_0100; ppout2 = 30'h40; in_tag = 9;
        @(negedge clk);
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_stale: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || product !== 32'h0000_0200 || out_tag !== 4'd9) begin
            n_err++;
            $display("FAIL midrst_after: valid=%b product=%h tag=%0d, want 1/00000200/9", out_valid, product, out_tag);
        end
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_random();
        logic [31:0]      exp_p [$];
        logic [TAG_W-1:0] exp_t [$];
        logic [31:0]      acc_m, held_p, e_p;
        logic [TAG_W-1:0] held_t, e_t;
        logic             hold;
        int               cyc;
        do_reset();
        acc_m = 0; hold = 0; cyc = 0;
        while ((cyc < 600 || exp_p.size() != 0) && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (cyc < 600) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ppout1 = $urandom; ppout2 = 30'($urandom);
                in_tag = TAG_W'($urandom); acc_clr = ($urandom_range(0, 7) == 0);
            end else in_valid = 0;
            #1;
            if (hold) begin
                n_cmp++;
                if (product !== held_p || out_tag !== held_t) begin
                    n_err++;
                    $display("FAIL rnd_stable cyc%0d: product=%h tag=%0d, want %h/%0d", cyc, product, out_tag, held_p, held_t);
                end
            end
            hold = out_valid && !out_ready;
            held_p = product; held_t = out_tag;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_p.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious cyc%0d: product=%h with nothing pending", cyc, product);
                end else begin
                    e_p = exp_p.pop_front(); e_t = exp_t.pop_front();
                    if (product !== e_p || out_tag !== e_t) begin
                        n_err++;
                        $display("FAIL rnd_data cyc%0d: product=%h tag=%0d, want %h/%0d", cyc, product, out_tag, e_p, e_t);
                    end
                end
            end
            if (in_valid && in_ready) begin
`ifdef MUL_ACC_EN
                acc_m = (acc_clr ? 32'd0 : acc_m) + ref_sum(ppout1, ppout2);
`else
                acc_m = ref_sum(ppout1, ppout2);
`endif
                exp_p.push_back(acc_m); exp_t.push_back(in_tag);
            end
        end
        n_cmp++;
        if (exp_p.size() != 0) begin
            n_err++; $display("FAIL rnd_drain: %0d results never emerged, want 0", exp_p.size());
        end
        in_valid = 0; acc_clr = 0;
    endtask

`ifdef MUL_ACC_EN
    task automatic test_acc();
        logic [31:0] p1 [3];
        logic        cl [3];
        logic [31:0] ex [3];
        int          ni, no, cyc;
        p1[0] = 32'd1; cl[0] = 0; ex[0] = 32'd5;
        p1[1] = 32'd3; cl[1] = 0; ex[1] = 32'd12;
        p1[2] = 32'd1; cl[2] = 1; ex[2] = 32'd1;
        do_reset();
        ni = 0; no = 0; cyc = 0;
        while (no < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = !(cyc == 2 || cyc == 3);
            in_valid = (ni < 3);
            if (ni < 3) begin
                // ppout2 = 1 contributes 4, so the sums are 5, 7, 5... except op 2 which sums to 1
                ppout1 = p1[ni]; ppout2 = (ni == 2) ? 30'd0 : 30'd1;
                if (ni == 1) ppout1 = 32'd3;
                acc_clr = cl[ni]; in_tag = TAG_W'(ni);
            end
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (product !== ex[no] || out_tag !== TAG_W'(no)) begin
                    n_err++;
                    $display("FAIL acc%0d: product=%0d tag=%0d, want %0d/%0d", no, product, out_tag, ex[no], no);
                end
                no++;
            end
            if (in_valid && in_ready) ni++;
        end
        n_cmp++;
        if (no != 3) begin
            n_err++; $display("FAIL acc_timeout: got %0d results, want 3", no);
        end
        in_valid = 0; acc_clr = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
`ifdef MUL_ACC_EN
        test_acc();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
